// File: rtl/flipflop_pkg.sv
// Shared definitions for the configurable flip-flop bank.
package flipflop_pkg;

   // Per-cycle function select carried on the mode port.
   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_JK = 2'b10,
      MODE_SR = 2'b11
   } mode_e;

   // True when an SR operation would drive S and R high together.
   function automatic logic sr_conflict(input mode_e m, input logic s, input logic r);
      return (m == MODE_SR) && s && r;
   endfunction

endpackage : flipflop_pkg

// File: rtl/flipflop_bank_ff_cell.sv
// Next-state logic for a single flip-flop bit. Purely combinational;
// the state register itself lives in the bank.
module ff_cell
   import flipflop_pkg::*;
(
   input  logic  q,
   input  logic  a,
   input  logic  b,
   input  mode_e mode,
   output logic  q_next
);

   // Select the behaviour for this bit from the current mode and operands.
   always_comb begin
      q_next = q;
      case (mode)
         MODE_D:  q_next = a;
         MODE_T:  q_next = q ^ a;
         MODE_JK: begin
            case ({a, b})
               2'b10:   q_next = 1'b1;
               2'b01:   q_next = 1'b0;
               2'b11:   q_next = ~q;
               default: q_next = q;
            endcase
         end
         MODE_SR: begin
            // S=R=1 is illegal; the bit holds and the bank flags it.
            case ({a, b})
               2'b10:   q_next = 1'b1;
               2'b01:   q_next = 1'b0;
               default: q_next = q;
            endcase
         end
         default: q_next = q;
      endcase
   end

endmodule : ff_cell

// File: rtl/flipflop_bank.sv
// Bank of WIDTH independent flip-flops whose type (D/T/JK/SR) is chosen
// every cycle, with per-bit change flags and a sticky illegal-SR flag.
module flipflop_bank
   import flipflop_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic [WIDTH-1:0] chg,
   output logic             sr_err
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] chg_q;
   logic [WIDTH-1:0] chg_d;
   logic [WIDTH-1:0] conflict_bits;
   logic             sr_err_q;
   logic             sr_err_d;
   mode_e            mode_sel;

   assign mode_sel = mode_e'(mode);

   // One next-state cell per bit; every bit sees the same mode.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         ff_cell u_cell (
            .q      (q_q[gi]),
            .a      (a[gi]),
            .b      (b[gi]),
            .mode   (mode_sel),
            .q_next (q_d[gi])
         );
         assign conflict_bits[gi] = sr_conflict(mode_sel, a[gi], b[gi]);
      end
   endgenerate

   // Change flags and sticky error only advance on enabled edges.
   always_comb begin
      chg_d    = '0;
      sr_err_d = sr_err_q;
      if (en) begin
         chg_d    = q_d ^ q_q;
         sr_err_d = sr_err_q | (|conflict_bits);
      end
   end

   // State registers; clear dominates enable and every mode.
   always_ff @(posedge clk) begin
      if (clr) begin
         q_q      <= RESET_VAL;
         chg_q    <= '0;
         sr_err_q <= 1'b0;
      end else begin
         if (en) begin
            q_q <= q_d;
         end
         chg_q    <= chg_d;
         sr_err_q <= sr_err_d;
      end
   end

   assign Q      = q_q;
   assign Qn     = ~q_q;
   assign chg    = chg_q;
   assign sr_err = sr_err_q;

endmodule : flipflop_bank

// File: tb/tb_flipflop_bank.sv
// Randomised and directed checks of flipflop_bank against a behavioural model.
module tb_flipflop_bank;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic         en = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] Q, Qn, chg;
   logic         sr_err;

   flipflop_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
      .clk(clk), .clr(clr), .en(en), .mode(mode), .a(a), .b(b),
      .Q(Q), .Qn(Qn), .chg(chg), .sr_err(sr_err)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [W-1:0] q_m;
   logic [W-1:0] chg_m;
   logic         err_m;
   bit           valid = 1'b0;
   int           n_vec = 0;
   int           n_bad = 0;

   // Characteristic equations of each flip-flop type, whole word at once.
   function automatic logic [W-1:0] model_next(input logic [1:0] m, input logic [W-1:0] q,
                                               input logic [W-1:0] aa, input logic [W-1:0] bb);
      case (m)
         2'd0:    return aa;
         2'd1:    return q ^ aa;
         2'd2:    return (aa & ~q) | (~bb & q);
         default: return (aa & ~bb) | (q & ~(aa ^ bb));
      endcase
   endfunction

   // Apply one set of inputs across one rising edge and advance the model.
   task automatic step(input logic c, input logic e, input logic [1:0] m,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
      logic [W-1:0] nq;
      clr = c; en = e; mode = m; a = aa; b = bb;
      @(posedge clk);
      if (c) begin
         q_m = '0; chg_m = '0; err_m = 1'b0; valid = 1'b1;
      end else if (e) begin
         nq    = model_next(m, q_m, aa, bb);
         chg_m = nq ^ q_m;
         q_m   = nq;
         if (m == 2'd3 && (aa & bb) != '0) err_m = 1'b1;
      end else begin
         chg_m = '0;
      end
      #1;
   endtask

   task automatic check_lit(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (valid) begin
         n_vec++;
         if (Q !== q_m) begin n_bad++; $display("FAIL Q: got %b expected %b", Q, q_m); end
         if (Qn !== ~q_m) begin n_bad++; $display("FAIL Qn: got %b expected %b", Qn, ~q_m); end
         if (chg !== chg_m) begin n_bad++; $display("FAIL chg: got %b expected %b", chg, chg_m); end
         if (sr_err !== err_m) begin n_bad++; $display("FAIL sr_err: got %b expected %b", sr_err, err_m); end
      end
   end

   initial begin
      // Scenario 1: reset with garbage on every other input
      step(1'b1, 1'b1, 2'b11, 4'b1111, 4'b1111);
      check_lit("rst_Q", Q, 4'b0000);
      check_lit("rst_Qn", Qn, 4'b1111);
      check_lit("rst_chg", chg, 4'b0000);
      check_lit("rst_err", {3'b000, sr_err}, 4'b0000);
      $display("reset: Q=%b Qn=%b chg=%b sr_err=%b", Q, Qn, chg, sr_err);

      // Scenario 2: T mode, all ones, three edges
      step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000);
      check_lit("t1_Q", Q, 4'b1111); check_lit("t1_chg", chg, 4'b1111);
      step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000);
      check_lit("t2_Q", Q, 4'b0000); check_lit("t2_chg", chg, 4'b1111);
      step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000);
      check_lit("t3_Q", Q, 4'b1111); check_lit("t3_chg", chg, 4'b1111);
      $display("toggle: Q=%b chg=%b", Q, chg);

      // Scenario 3: JK from 0101
      step(1'b0, 1'b1, 2'b00, 4'b0101, 4'b0000);
      step(1'b0, 1'b1, 2'b10, 4'b1100, 4'b1010);
      check_lit("jk_Q", Q, 4'b1101); check_lit("jk_chg", chg, 4'b1000);
      $display("jk: Q=%b chg=%b", Q, chg);

      // Scenario 4: SR with an illegal bit, sticky error, cleared by clr
      step(1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);
      step(1'b0, 1'b1, 2'b11, 4'b0011, 4'b0001);
      check_lit("sr_Q", Q, 4'b0010); check_lit("sr_err1", {3'b000, sr_err}, 4'b0001);
      step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);
      step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);
      check_lit("sr_err_sticky", {3'b000, sr_err}, 4'b0001);
      step(1'b1, 1'b0, 2'b11, 4'b0000, 4'b0000);
      check_lit("sr_err_clr", {3'b000, sr_err}, 4'b0000);
      $display("sr: Q=%b sr_err=%b", Q, sr_err);

      // Scenario 5: enable low holds, clear beats enable
      step(1'b0, 1'b1, 2'b00, 4'b0110, 4'b0000);
      step(1'b0, 1'b0, 2'b00, 4'b1010, 4'b0000);
      check_lit("en0_Q", Q, 4'b0110); check_lit("en0_chg", chg, 4'b0000);
      step(1'b1, 1'b1, 2'b00, 4'b1010, 4'b0000);
      check_lit("prio_Q", Q, 4'b0000);
      $display("enable/priority: Q=%b chg=%b", Q, chg);

      // Scenario 6: reset mid-toggle, then resume from RESET_VAL
      step(1'b0, 1'b1, 2'b01, 4'b0001, 4'b0000);
      check_lit("mid_pre", Q, 4'b0001);
      step(1'b1, 1'b1, 2'b01, 4'b0001, 4'b0000);
      check_lit("mid_clr", Q, 4'b0000);
      step(1'b0, 1'b1, 2'b01, 4'b0001, 4'b0000);
      check_lit("mid_r1", Q, 4'b0001);
      step(1'b0, 1'b1, 2'b01, 4'b0001, 4'b0000);
      check_lit("mid_r2", Q, 4'b0000);
      $display("reset mid-op: Q=%b", Q);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
         $display("rand %0d: clr=%b en=%b mode=%b a=%b b=%b -> Q=%b chg=%b sr_err=%b",
                  i, clr, en, mode, a, b, Q, chg, sr_err);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_flipflop_bank
